acc_button_sequencer: RTL

ACC_BUTTON_SEQUENCER -- requirements
Module: acc_button_sequencer

---
 rtl/acc_button_sequencer_pkg.sv | 36 +++
 rtl/acc_button_sequencer_if.sv | 29 ++
 rtl/acc_button_sequencer_btn_debounce.sv | 64 ++++++
 rtl/acc_button_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/acc_button_sequencer_pkg.sv
// Shared definitions for the accumulator button sequencer: FSM state
// encoding, button index constants and the command priority helper.
package acc_button_sequencer_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ISSUE        = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } seq_state_e;

    // Button positions within btn[] and within the one-hot command vector.
    localparam int BTN_CLEAR = 0;
    localparam int BTN_LOAD  = 1;
    localparam int BTN_ADD   = 2;
    localparam int NUM_BTN   = 3;

    // Debounced level pattern meaning "add held, nothing else held".
    localparam logic [NUM_BTN-1:0] BTN_MASK_ADD = 3'b100;

    // Select one command from simultaneous rises: clear beats load beats add.
    // Losing rises are simply dropped.
    function automatic logic [NUM_BTN-1:0] pick_cmd(input logic [NUM_BTN-1:0] rise);
        logic [NUM_BTN-1:0] win;
        win = '0;
        if (rise[BTN_CLEAR]) begin
            win[BTN_CLEAR] = 1'b1;
        end else if (rise[BTN_LOAD]) begin
            win[BTN_LOAD] = 1'b1;
        end else if (rise[BTN_ADD]) begin
            win[BTN_ADD] = 1'b1;
        end
        return win;
    endfunction

endpackage

// File: rtl/acc_button_sequencer_if.sv
// Signal bundle between the button panel / accumulator and the sequencer.
// btn is raw and asynchronous; acc_reset/acc_load/acc_add are one-cycle
// command pulses with no handshake (the accumulator samples them every
// cycle); busy and cmd_count are plain status levels; dbg_state mirrors the
// sequencer FSM state for observation.
interface acc_button_sequencer_if;
    import acc_button_sequencer_pkg::*;

    logic [NUM_BTN-1:0] btn;
    logic               acc_reset;
    logic               acc_load;
    logic               acc_add;
    logic               busy;
    logic [7:0]         cmd_count;
    seq_state_e         dbg_state;

    // Panel / accumulator side.
    modport master (
        output btn,
        input  acc_reset, acc_load, acc_add, busy, cmd_count, dbg_state
    );

    // Sequencer side.
    modport slave (
        input  btn,
        output acc_reset, acc_load, acc_add, busy, cmd_count, dbg_state
    );

endinterface

// File: rtl/acc_button_sequencer_btn_debounce.sv
// Single-button conditioner: 2-flop synchronizer followed by a debounce
// counter. The debounced level only flips after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any agreement in
// between restarts the count. rise is a registered one-cycle strobe that
// accompanies a 0->1 flip of the level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    // Next-state: synchronizer shift and debounce counting.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/acc_button_sequencer.sv
// Turns three raw push-buttons (clear, load, add) into clean one-cycle
// command pulses for an adder-accumulator. Each press issues exactly one
// command; presses made while another button is held are ignored until
// everything is released. cmd_count counts issued commands modulo 256.
// Optional feature macro: SEQ_AUTO_REPEAT_EN -- while add alone stays held
// after its first pulse, re-issue acc_add every REPEAT_CYCLES cycles.
module acc_button_sequencer
    import acc_button_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    acc_button_sequencer_if.slave  bus
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock  (clock),
            .reset  (reset),
            .btn_raw(bus.btn[i]),
            .level  (level[i]),
            .rise   (rise[i])
        );
    end

    seq_state_e         state_q, state_d;
    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic [7:0]         cmd_count_q, cmd_count_d;

`ifdef SEQ_AUTO_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    // Cycles elapsed since the last add pulse while add alone is held.
    logic [RW-1:0] rep_q, rep_d;
`endif

    // FSM next-state: the pulse is registered on entry to ISSUE so it shows
    // up one cycle after the debounced rise and lasts for the ISSUE cycle.
    always_comb begin
        state_d     = state_q;
        pulse_d     = '0;
        cmd_count_d = cmd_count_q;
`ifdef SEQ_AUTO_REPEAT_EN
        rep_d       = rep_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|rise) begin
                    state_d     = ST_ISSUE;
                    pulse_d     = pick_cmd(rise);
                    cmd_count_d = cmd_count_q + 8'd1;
                end
`ifdef SEQ_AUTO_REPEAT_EN
                rep_d = '0;
`endif
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_RELEASE;
`ifdef SEQ_AUTO_REPEAT_EN
                // The initial pulse cycle already counts toward the interval.
                rep_d = RW'(1);
`endif
            end
            ST_WAIT_RELEASE: begin
                if (level == '0) begin
                    state_d = ST_IDLE;
`ifdef SEQ_AUTO_REPEAT_EN
                    rep_d = '0;
`endif
                end
`ifdef SEQ_AUTO_REPEAT_EN
                else if (level == BTN_MASK_ADD) begin
                    if (rep_q == REP_LAST) begin
                        pulse_d[BTN_ADD] = 1'b1;
                        cmd_count_d      = cmd_count_q + 8'd1;
                        rep_d            = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end else begin
                    // Clear or load involved: restart the repeat interval.
                    rep_d = '0;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM and output registers; reset kills any pulse in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pulse_q     <= '0;
            busy_q      <= 1'b0;
            cmd_count_q <= 8'd0;
`ifdef SEQ_AUTO_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            cmd_count_q <= cmd_count_d;
`ifdef SEQ_AUTO_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign bus.acc_reset = pulse_q[BTN_CLEAR];
    assign bus.acc_load  = pulse_q[BTN_LOAD];
    assign bus.acc_add   = pulse_q[BTN_ADD];
    assign bus.busy      = busy_q;
    assign bus.cmd_count = cmd_count_q;
    assign bus.dbg_state = state_q;

endmodule
